// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   It tracks {valid, dst, reg_write, mem_read} for the instructions in EX, MEM
//   and WB. From these records it produces:
//     - registered EX operand forwarding selects;
//     - a one-cycle load-use stall with an EX bubble;
//     - a squash of IF/ID and ID/EX when a taken branch resolves in MEM.
//   It also keeps saturating stall and flush event counters.
// Ports
//   clk, reset          clock, synchronous active-low reset
//   hold                global freeze; all tracked state holds
//   id_*                attributes of the instruction currently in ID
//   br_taken            taken branch resolved in MEM
//   stall_if            hold PC and IF/ID (combinational)
//   bubble_ex           load a NOP into ID/EX (combinational)
//   flush               squash IF/ID and ID/EX (combinational)
//   fwd_a, fwd_b        EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB
//   stall_cnt           saturating count of load-use stall cycles
//   flush_cnt           saturating count of taken-branch flushes
module hazard_fwd_unit #(
   parameter int RA_W     = 3,
   parameter bit ZERO_REG = 1'b1,
   parameter bit WB_FWD   = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [RA_W-1:0]  id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             br_taken,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Pipeline records: _p0 = EX, _p1 = MEM, _p2 = WB
   logic            vld_p0, rw_p0, mr_p0;
   logic [RA_W-1:0] dst_p0;
   logic            vld_p1, rw_p1, mr_p1;
   logic [RA_W-1:0] dst_p1;
   logic            vld_p2, rw_p2;
   logic [RA_W-1:0] dst_p2;

   logic wr_p0, wr_p1, wr_p2;
   logic lu, bubble;
   logic [1:0] sel_a, sel_b;

   // A record only counts as a producer if it really writes a non-hardwired register.
   function automatic logic writing(input logic vld, input logic rw, input logic [RA_W-1:0] dst);
      return vld & rw & ~(ZERO_REG && (dst == '0));
   endfunction

   // Youngest producer wins: EX (01) over MEM (10) over WB (11).
   function automatic logic [1:0] fwd_sel(input logic use_src, input logic [RA_W-1:0] src,
                                          input logic ex_wr, input logic [RA_W-1:0] ex_dst,
                                          input logic mem_wr, input logic [RA_W-1:0] mem_dst,
                                          input logic wb_wr, input logic [RA_W-1:0] wb_dst);
      if (!use_src)                               return 2'b00;
      else if (ex_wr && (src == ex_dst))          return 2'b01;
      else if (mem_wr && (src == mem_dst))        return 2'b10;
      else if (WB_FWD && wb_wr && (src == wb_dst)) return 2'b11;
      else                                        return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

   always_comb begin
      wr_p0 = writing(vld_p0, rw_p0, dst_p0);
      wr_p1 = writing(vld_p1, rw_p1, dst_p1);
      wr_p2 = writing(vld_p2, rw_p2, dst_p2);

      lu = id_valid & wr_p0 & mr_p0 &
           ((id_use_rs & (id_rs == dst_p0)) | (id_use_rt & (id_rt == dst_p0)));

      // A taken branch squashes the dependent instruction anyway, so flush beats stall.
      flush     = reset & br_taken & ~hold;
      stall_if  = reset & lu & ~br_taken & ~hold;
      bubble_ex = stall_if;

      // EX receives a NOP when ID is squashed, stalled or empty.
      bubble = flush | stall_if | ~id_valid;

      sel_a = fwd_sel(id_use_rs, id_rs, wr_p0, dst_p0, wr_p1, dst_p1, wr_p2, dst_p2);
      sel_b = fwd_sel(id_use_rt, id_rt, wr_p0, dst_p0, wr_p1, dst_p1, wr_p2, dst_p2);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p0    <= 1'b0;
         rw_p0     <= 1'b0;
         mr_p0     <= 1'b0;
         vld_p1    <= 1'b0;
         rw_p1     <= 1'b0;
         mr_p1     <= 1'b0;
         vld_p2    <= 1'b0;
         rw_p2     <= 1'b0;
         fwd_a     <= 2'b00;
         fwd_b     <= 2'b00;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!hold) begin
         // MEM -> WB
         vld_p2 <= vld_p1;
         rw_p2  <= rw_p1;
         dst_p2 <= dst_p1;
         // EX -> MEM, squashed by a taken branch
         vld_p1 <= vld_p0 & ~br_taken;
         rw_p1  <= rw_p0;
         mr_p1  <= mr_p0;
         dst_p1 <= dst_p0;
         // ID -> EX; selects travel with the instruction they were computed for
         vld_p0 <= ~bubble;
         rw_p0  <= id_reg_write;
         mr_p0  <= id_mem_read;
         dst_p0 <= id_dst;
         fwd_a  <= bubble ? 2'b00 : sel_a;
         fwd_b  <= bubble ? 2'b00 : sel_b;
         if (stall_if) stall_cnt <= sat_inc(stall_cnt);
         if (flush)    flush_cnt <= sat_inc(flush_cnt);
      end
   end

endmodule
